// File: rtl/issue_scoreboard.sv
// In-order issue stage: holds one decoded instruction and tracks pending destination
// registers in a busy scoreboard, stalling decode on RAW/WAW hazards until writeback.
package issue_scoreboard_pkg;

    typedef struct packed {
        logic [4:0]  rs1_sel;
        logic [4:0]  rs2_sel;
        logic [4:0]  rd_sel;
        logic [31:0] imm32;
        logic [3:0]  alu_op;
    } rv32_instr_packet_t;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_sel;
        logic [31:0] wb_data;
    } rv32_writeback_packet_t;

endpackage

module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   instr_in_valid,
    output logic                   instr_in_ready,
    input  rv32_instr_packet_t     instruction_packet,
    input  rv32_writeback_packet_t writeback_packet,
    input  logic                   flush,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output rv32_instr_packet_t     issue_instr,
    output logic [31:0]            busy_vec,
    output logic [STALL_CNT_W-1:0] hazard_stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

    stage_state_t           state_q;
    stage_state_t           state_d;
    logic [31:0]            busy_q;
    logic [31:0]            busy_d;
    rv32_instr_packet_t     held_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic hazard;
    logic space;
    logic accept;
    logic handshake;
    logic stall;
    logic wb_clear;
    logic flush_clear;

    // Register file data rides on the same bus but only the select/enable matter here.
    logic unused_wb_data;
    assign unused_wb_data = ^writeback_packet.wb_data;

    assign issue_valid        = (state_q == FULL);
    assign issue_instr        = held_q;
    assign busy_vec           = busy_q;
    assign hazard_stall_count = stall_q;

    // Hazards look only at the registered scoreboard, so there is no writeback bypass.
    assign hazard = busy_q[instruction_packet.rs1_sel]
                  | busy_q[instruction_packet.rs2_sel]
                  | busy_q[instruction_packet.rd_sel];

    assign space          = !issue_valid || issue_ready;
    assign instr_in_ready = space && !hazard && !flush;
    assign accept         = instr_in_valid && instr_in_ready;
    assign handshake      = issue_valid && issue_ready;
    assign stall          = instr_in_valid && space && hazard && !flush;

    assign wb_clear    = writeback_packet.wb_en && (writeback_packet.wb_sel != 5'd0);
    assign flush_clear = flush && issue_valid && (held_q.rd_sel != 5'd0);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if (handshake) begin
            state_d = EMPTY;
        end
    end

    // Clears are applied first so a same-edge accept on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_clear) begin
            busy_d[writeback_packet.wb_sel] = 1'b0;
        end
        if (flush_clear) begin
            busy_d[held_q.rd_sel] = 1'b0;
        end
        if (accept && (instruction_packet.rd_sel != 5'd0)) begin
            busy_d[instruction_packet.rd_sel] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            busy_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (accept) begin
                held_q <= instruction_packet;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (stall && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Table-driven bench for issue_scoreboard: per-cycle vectors with expected state, plus a
// queue of accepted instructions compared against the held instruction as it issues.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    typedef struct {
        logic               in_valid;
        rv32_instr_packet_t pkt;
        logic               wb_en;
        logic [4:0]         wb_sel;
        logic [31:0]        wb_data;
        logic               flush;
        logic               issue_ready;
        logic               exp_ready;
        logic [31:0]        exp_busy;
        logic               exp_iv;
        logic [3:0]         exp_cnt;
        logic               chk_rs1;
        logic [31:0]        exp_rs1;
    } vec_t;

    logic                   clk;
    logic                   resetn;
    logic                   instr_in_valid;
    logic                   instr_in_ready;
    rv32_instr_packet_t     instruction_packet;
    rv32_writeback_packet_t writeback_packet;
    logic                   flush;
    logic                   issue_valid;
    logic                   issue_ready;
    rv32_instr_packet_t     issue_instr;
    logic [31:0]            busy_vec;
    logic [3:0]             hazard_stall_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    rv32_instr_packet_t expq[$];
    logic [31:0] rf [32];

    issue_scoreboard #(.STALL_CNT_W(4)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .instr_in_valid     (instr_in_valid),
        .instr_in_ready     (instr_in_ready),
        .instruction_packet (instruction_packet),
        .writeback_packet   (writeback_packet),
        .flush              (flush),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_instr        (issue_instr),
        .busy_vec           (busy_vec),
        .hazard_stall_count (hazard_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file on the shared writeback bus, read through issue_instr.
    always_ff @(posedge clk) begin
        if (writeback_packet.wb_en && writeback_packet.wb_sel != 5'd0) begin
            rf[writeback_packet.wb_sel] <= writeback_packet.wb_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic rv32_instr_packet_t instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [4:0] rd);
        rv32_instr_packet_t p;
        p.rs1_sel = rs1;
        p.rs2_sel = rs2;
        p.rd_sel  = rd;
        p.imm32   = {8'hC0, 3'b0, rs1, 3'b0, rs2, 3'b0, rd};
        p.alu_op  = rd[3:0] ^ 4'h5;
        return p;
    endfunction

    function automatic void add_vec(input logic in_valid, input rv32_instr_packet_t pkt,
                                    input int wb, input logic fl, input logic irdy,
                                    input logic exp_ready, input logic [31:0] exp_busy,
                                    input logic exp_iv, input logic [3:0] exp_cnt);
        vec_t v;
        v.in_valid    = in_valid;
        v.pkt         = pkt;
        v.wb_en       = (wb > 0);
        v.wb_sel      = (wb > 0) ? wb[4:0] : 5'd0;
        v.wb_data     = (wb == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(wb));
        v.flush       = fl;
        v.issue_ready = irdy;
        v.exp_ready   = exp_ready;
        v.exp_busy    = exp_busy;
        v.exp_iv      = exp_iv;
        v.exp_cnt     = exp_cnt;
        v.chk_rs1     = 1'b0;
        v.exp_rs1     = 32'd0;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        instr_in_valid     = 1'b0;
        instruction_packet = '0;
        writeback_packet   = '0;
        flush              = 1'b0;
        issue_ready        = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx, input logic held);
        @(negedge clk);
        instr_in_valid          = v.in_valid;
        instruction_packet      = v.pkt;
        writeback_packet.wb_en   = v.wb_en;
        writeback_packet.wb_sel  = v.wb_sel;
        writeback_packet.wb_data = v.wb_data;
        flush                   = v.flush;
        issue_ready             = v.issue_ready;
        #1;
        checkOutput($sformatf("v%0d instr_in_ready", idx), 64'(instr_in_ready), 64'(v.exp_ready));
        if (held) begin
            if (expq.size() == 0) begin
                checkOutput($sformatf("v%0d scoreboard queue empty", idx), 64'(0), 64'(1));
            end else begin
                checkOutput($sformatf("v%0d issue_instr", idx), 64'(issue_instr), 64'(expq[0]));
                if (v.issue_ready || v.flush) void'(expq.pop_front());
            end
        end
        if (v.in_valid && v.exp_ready) expq.push_back(v.pkt);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d busy_vec", idx), 64'(busy_vec), 64'(v.exp_busy));
        checkOutput($sformatf("v%0d issue_valid", idx), 64'(issue_valid), 64'(v.exp_iv));
        checkOutput($sformatf("v%0d stall_count", idx), 64'(hazard_stall_count), 64'(v.exp_cnt));
        if (v.chk_rs1) begin
            checkOutput($sformatf("v%0d rs1 read", idx), 64'(rf[issue_instr.rs1_sel]), 64'(v.exp_rs1));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " busy_vec"}, 64'(busy_vec), 64'(0));
        checkOutput({tag, " issue_valid"}, 64'(issue_valid), 64'(0));
        checkOutput({tag, " issue_instr"}, 64'(issue_instr), 64'(0));
        checkOutput({tag, " stall_count"}, 64'(hazard_stall_count), 64'(0));
    endtask

    initial begin
        logic prev_iv;
        rv32_instr_packet_t idle;
        idle = '0;

        // Independent stream, rd = 1,2,3, then writebacks (last one to a non-busy reg)
        add_vec(1, instr(0, 0, 1), 0, 0, 1, 1, 32'h2, 1, 0);
        add_vec(1, instr(0, 0, 2), 0, 0, 1, 1, 32'h6, 1, 0);
        add_vec(1, instr(0, 0, 3), 0, 0, 1, 1, 32'hE, 1, 0);
        add_vec(0, idle, 0, 0, 1, 1, 32'hE, 0, 0);
        add_vec(0, idle, 1, 0, 1, 1, 32'hC, 0, 0);
        add_vec(0, idle, 2, 0, 1, 1, 32'h8, 0, 0);
        add_vec(0, idle, 3, 0, 1, 1, 32'h0, 0, 0);
        add_vec(0, idle, 4, 0, 1, 1, 32'h0, 0, 0);
        // RAW on x5 (rs1 then rs2), writeback in W, accept at end of W+1
        add_vec(1, instr(0, 0, 5), 0, 0, 1, 1, 32'h20, 1, 0);
        add_vec(1, instr(5, 0, 6), 0, 0, 1, 0, 32'h20, 0, 1);
        add_vec(1, instr(0, 5, 6), 0, 0, 1, 0, 32'h20, 0, 2);
        add_vec(1, instr(5, 0, 6), 5, 0, 1, 0, 32'h0, 0, 3);
        add_vec(1, instr(5, 0, 6), 0, 0, 1, 1, 32'h40, 1, 3);
        vecs[vecs.size()-1].chk_rs1 = 1'b1;
        vecs[vecs.size()-1].exp_rs1 = 32'hDEADBEEF;
        add_vec(0, idle, 6, 0, 1, 1, 32'h0, 0, 3);
        // x0 never sets busy and never stalls
        add_vec(1, instr(0, 0, 0), 0, 0, 1, 1, 32'h0, 1, 3);
        add_vec(1, instr(0, 3, 0), 0, 0, 1, 1, 32'h0, 1, 3);
        add_vec(0, idle, 0, 0, 1, 1, 32'h0, 0, 3);
        // Back-pressure: full stage with issue_ready low, no stall counting
        add_vec(1, instr(0, 0, 8), 0, 0, 0, 1, 32'h100, 1, 3);
        add_vec(1, instr(1, 0, 10), 0, 0, 0, 0, 32'h100, 1, 3);
        add_vec(1, instr(1, 0, 10), 0, 0, 0, 0, 32'h100, 1, 3);
        add_vec(1, instr(1, 0, 10), 0, 0, 1, 1, 32'h500, 1, 3);
        add_vec(0, idle, 0, 0, 1, 1, 32'h500, 0, 3);
        add_vec(0, idle, 8, 0, 1, 1, 32'h400, 0, 3);
        add_vec(0, idle, 10, 0, 1, 1, 32'h0, 0, 3);
        // Same-edge accept and writeback on x7: set wins
        add_vec(1, instr(0, 0, 7), 7, 0, 1, 1, 32'h80, 1, 3);
        add_vec(0, idle, 7, 0, 1, 1, 32'h0, 0, 3);
        // Flush held rd=9 alongside writeback of issued rd=12
        add_vec(1, instr(0, 0, 12), 0, 0, 1, 1, 32'h1000, 1, 3);
        add_vec(1, instr(0, 0, 9), 0, 0, 1, 1, 32'h1200, 1, 3);
        add_vec(1, instr(0, 12, 13), 12, 1, 0, 0, 32'h0, 0, 3);
        // WAW stall on x14 long enough to saturate the 4-bit counter
        add_vec(1, instr(0, 0, 14), 0, 0, 1, 1, 32'h4000, 1, 3);
        for (int k = 0; k < 14; k++) begin
            add_vec(1, instr(0, 0, 14), 0, 0, 1, 0, 32'h4000, 0, (k < 11) ? 4'(4 + k) : 4'd15);
        end
        add_vec(1, instr(0, 0, 14), 14, 0, 1, 0, 32'h0, 0, 15);
        add_vec(1, instr(0, 0, 14), 0, 0, 1, 1, 32'h4000, 1, 15);
        add_vec(0, idle, 14, 0, 1, 1, 32'h0, 0, 15);

        resetn = 1'b0;
        driveIdle();
        #12;
        checkResetState("reset asserted");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkResetState("reset released");

        prev_iv = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i, prev_iv);
            prev_iv = vecs[i].exp_iv;
        end

        // Asynchronous reset in the middle of a cycle with state pending
        @(negedge clk);
        instr_in_valid     = 1'b1;
        instruction_packet = instr(0, 0, 20);
        issue_ready        = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre-reset busy_vec", 64'(busy_vec), 64'(32'h0010_0000));
        checkOutput("pre-reset issue_valid", 64'(issue_valid), 64'(1));
        #2;
        resetn = 1'b0;
        #1;
        checkResetState("async reset");
        driveIdle();
        expq.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("after async reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
